// File: rtl/fetch_pc_sequencer_pkg.sv
// Shared types and defaults for the fetch PC sequencer.
package fetch_pc_sequencer_pkg;

  typedef enum logic [1:0] {
    StBoot   = 2'd0,
    StFetch  = 2'd1,
    StHalted = 2'd2
  } fetch_state_e;

  localparam int unsigned InstrBytes     = 4;
  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

endpackage : fetch_pc_sequencer_pkg

// File: rtl/fetch_pc_next.sv
// Next-PC selection: redirect beats sequential increment, which beats hold.
module fetch_pc_next
  import fetch_pc_sequencer_pkg::*;
#(
  parameter int unsigned INSTR_BYTES = InstrBytes
) (
  input  logic [31:0] pc_i,
  input  logic        accept_i,
  input  logic        taken_i,
  input  logic [31:0] target_i,
  output logic [31:0] pc_next_o,
  output logic        misalign_o
);

  logic aligned;

  always_comb begin
    aligned    = (target_i[1:0] == 2'b00);
    misalign_o = taken_i & ~aligned;
    pc_next_o  = pc_i;
    if (taken_i) begin
      // A misaligned target leaves the PC where it is; the sequencer halts.
      if (aligned) begin
        pc_next_o = target_i;
      end
    end else if (accept_i) begin
      pc_next_o = pc_i + 32'(INSTR_BYTES);
    end
  end

endmodule : fetch_pc_next

// File: rtl/fetch_pc_sequencer.sv
// Fetch PC owner: issues sequential imem requests, redirects on taken branches,
// pulses flush on redirect and halts on a misaligned target.
module fetch_pc_sequencer
  import fetch_pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DefaultResetPc,
  parameter int unsigned INSTR_BYTES = InstrBytes,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk_pi,
  input  logic             rst_n_pi,
  input  logic             stall_pi,
  input  logic             isTakenBranch_pi,
  input  logic [31:0]      targetPC_pi,
  input  logic             imem_ready_pi,
  output logic             imem_req_po,
  output logic [31:0]      imem_addr_po,
  output logic             fetchValid_po,
  output logic [31:0]      fetchPC_po,
  output logic             flush_po,
  output logic             misalign_po,
  output logic [CNT_W-1:0] redirectCount_po
);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             fetch_valid_q, fetch_valid_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic             flush_q, flush_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic in_fetch;
  logic req;
  logic accept;
  logic taken;
  logic bad_target;
  logic redirect;

  always_comb begin
    in_fetch = (state_q == StFetch);
    // Request is retracted in a redirect cycle so the wrong-path address is never accepted.
    req      = in_fetch & ~stall_pi & ~isTakenBranch_pi;
    accept   = req & imem_ready_pi;
    taken    = in_fetch & isTakenBranch_pi;
  end

  fetch_pc_next #(
    .INSTR_BYTES (INSTR_BYTES)
  ) u_pc_next (
    .pc_i       (pc_q),
    .accept_i   (accept),
    .taken_i    (taken),
    .target_i   (targetPC_pi),
    .pc_next_o  (pc_d),
    .misalign_o (bad_target)
  );

  assign redirect = taken & ~bad_target;

  always_comb begin
    state_d       = state_q;
    fetch_valid_d = accept;
    fetch_pc_d    = accept ? pc_q : fetch_pc_q;
    flush_d       = taken;
    misalign_d    = misalign_q | bad_target;
    cnt_d         = cnt_q;
    if (redirect && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
    unique case (state_q)
      StBoot:   state_d = StFetch;
      StFetch:  if (bad_target) state_d = StHalted;
      StHalted: state_d = StHalted;
      default:  state_d = StHalted;
    endcase
  end

  always_ff @(posedge clk_pi or negedge rst_n_pi) begin
    if (!rst_n_pi) begin
      state_q       <= StBoot;
      pc_q          <= RESET_PC;
      fetch_valid_q <= 1'b0;
      fetch_pc_q    <= 32'h0;
      flush_q       <= 1'b0;
      misalign_q    <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_pc_q    <= fetch_pc_d;
      flush_q       <= flush_d;
      misalign_q    <= misalign_d;
      cnt_q         <= cnt_d;
    end
  end

  assign imem_req_po      = req;
  assign imem_addr_po     = pc_q;
  assign fetchValid_po    = fetch_valid_q;
  assign fetchPC_po       = fetch_pc_q;
  assign flush_po         = flush_q;
  assign misalign_po      = misalign_q;
  assign redirectCount_po = cnt_q;

endmodule : fetch_pc_sequencer
